spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Shares one SPI master engine (8-bit shift datapath with `start`, `cpol`, `cpha`, parallel TX/RX bytes) among `N_REQ` requesters. Round-robin arbitration, per-requester SPI mode applied with a settle window before `start`, completion detection, RX byte and per-requester acknowledge returned. Sits between client blocks and `spi_top`-style engine, which it exclusively sequences.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `SETUP_CYC`, 2: cycles mode is driven before `spi_start` (≥1).
- `TIMEOUT`, 255: max WAIT cycles for `spi_done` before error (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: level request, held until matching `ack`.
- `req_cpol` in N_REQ: per-requester clock polarity.
- `req_cpha` in N_REQ: per-requester clock phase.
- `req_tx` in 8*N_REQ: TX byte, requester i at bits [8i+7:8i].
- `gnt` out N_REQ: one-hot current owner, high SETUP..RESP.
- `ack` out N_REQ: one-cycle completion pulse to owner.
- `rdata` out 8: RX byte, valid with `ack`.
- `err` out 1: timeout flag, valid with `ack`.
- `busy` out 1: high whenever state ≠ IDLE.
- `spi_cpol`, `spi_cpha` out 1 each: mode to engine.
- `spi_start` out 1: one-cycle start pulse.
- `spi_tx` out 8: TX byte to engine.
- `spi_rx` in 8: engine RX byte.
- `spi_done` in 1: engine completion pulse.

## Operation
- FSM: IDLE → SETUP → START → WAIT → RESP → IDLE.
- IDLE: if any `req`, pick winner by rotating priority starting at `ptr`; register index, cpol, cpha, tx; set `gnt`; go SETUP. No request: stay.
- SETUP: drive `spi_cpol/cpha/tx` from latched values for `SETUP_CYC` cycles, then START.
- START: `spi_start`=1 exactly one cycle; go WAIT, clear timeout counter.
- WAIT: on `spi_done`, capture `spi_rx`, `err`=0, go RESP. Else counter increments; counter reaching `TIMEOUT` → `rdata`=0, `err`=1, go RESP.
- RESP: `ack[idx]`=1 one cycle; `ptr` ← idx+1 mod N_REQ; `gnt` cleared on exit.
- Inputs latched at grant; requester changes during transfer ignored. `req` dropped before grant simply loses the slot.
- `spi_cpol/cpha` retain last value in IDLE (no idle-level glitch on the bus).

## Timing
- Reset: all outputs 0, state IDLE, `ptr`=0, counter 0; takes effect immediately, mid-transaction included (engine shares `rst`).
- `req` high at edge k (IDLE) → `gnt` high after k; `spi_start` high for cycle after k+SETUP_CYC; `spi_done` sampled at edge d → `ack`/`rdata` high after d for one cycle; `busy` low after d+1.
- Back-to-back: minimum one IDLE cycle between RESP and next grant.
- `spi_done` and timeout expiry same cycle → done wins, `err`=0.
- `spi_done` outside WAIT ignored.
- `ack` never asserted for an index with `gnt` low.
- Counter width ceil(log2(TIMEOUT+1)); no wrap.

## Structure
- Package `spi_arb_pkg`: state enum (IDLE, SETUP, START, WAIT, RESP), `SPI_W`=8.
- Sub-module `rr_picker`: combinational rotating-priority one-hot select from `req` and `ptr`, plus valid flag and binary index.

## Test plan
- req0 only, mode 0, tx 8'h55; engine model returns 8'hA5 → gnt=0001, two SETUP cycles with cpol=cpha=0, single start, ack[0] with rdata=8'hA5, err=0.
- req1 mode 3 (cpol=cpha=1) tx 8'h42 → spi_cpol/cpha=1 for ≥2 cycles before start; stay 1 in IDLE afterwards.
- req0..3 all held continuously → grants 0,1,2,3,0 order; each ack pulse only to owner.
- Engine never pulses done, TIMEOUT=255 → ack after 255 WAIT cycles, err=1, rdata=8'h00; next request serviced normally.
- spi_done same cycle as timeout expiry → err=0, rdata=spi_rx.
- rst asserted during WAIT → outputs 0 immediately, busy=0; next req3 granted before others only if sole requester (ptr=0).

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared types for the SPI arbiter: FSM state encoding, SPI byte width and
// a small index helper used for the round-robin pointer.
package spi_arb_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    RESP
  } state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the SPI arbiter.
//   slave  : arbiter view (takes requests and engine status, drives grants,
//            acknowledges, result and engine controls)
//   master : environment view (client blocks plus SPI engine)
// Requester signals: req, req_cpol, req_cpha, req_tx -> gnt, ack, rdata, err, busy
// Engine signals:    spi_cpol, spi_cpha, spi_start, spi_tx -> spi_rx, spi_done
interface spi_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_cpol;
  logic [N_REQ-1:0]       req_cpha;
  logic [SPI_W*N_REQ-1:0] req_tx;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [SPI_W-1:0]       rdata;
  logic                   err;
  logic                   busy;

  logic                   spi_cpol;
  logic                   spi_cpha;
  logic                   spi_start;
  logic [SPI_W-1:0]       spi_tx;
  logic [SPI_W-1:0]       spi_rx;
  logic                   spi_done;

  modport slave (
    input  req, req_cpol, req_cpha, req_tx, spi_rx, spi_done,
    output gnt, ack, rdata, err, busy, spi_cpol, spi_cpha, spi_start, spi_tx
  );

  modport master (
    output req, req_cpol, req_cpha, req_tx, spi_rx, spi_done,
    input  gnt, ack, rdata, err, busy, spi_cpol, spi_cpha, spi_start, spi_tx
  );

endinterface

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational rotating-priority selector.
//   req    : request vector
//   ptr    : index holding highest priority this round
//   onehot : one-hot winner (all zero when nothing requests)
//   valid  : at least one request present
//   idx    : binary index of the winner
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         onehot,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin : pick
    int sel;
    onehot = '0;
    valid  = 1'b0;
    idx    = '0;
    sel    = 0;
    // Scan from ptr upward, wrapping; the first active request wins.
    for (int off = 0; off < N_REQ; off++) begin
      sel = (int'(ptr) + off) % N_REQ;
      if (!valid && req[sel]) begin
        valid       = 1'b1;
        onehot[sel] = 1'b1;
        idx         = IW'(sel);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one 8-bit SPI master engine among N_REQ requesters.
// A round-robin winner has its mode and TX byte latched at grant; the mode is
// presented to the engine for SETUP_CYC cycles before a single start pulse.
// Completion (or a timeout after TIMEOUT wait cycles) returns the RX byte and
// a one-cycle ack to the owner.
//   clk, rst : clock, asynchronous active-high reset (shared with the engine)
//   bus      : requester and engine signals (slave modport)
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  spi_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [N_REQ-1:0] gnt_q;
  logic             cpol_q, cpha_q;
  logic [SPI_W-1:0] tx_q;
  logic [SPI_W-1:0] rdata_q;
  logic             err_q;
  logic [SW-1:0]    setup_cnt;
  logic [CW-1:0]    wait_cnt;

  logic [N_REQ-1:0] pick_oh;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  logic             setup_last;
  logic             wait_expire;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign setup_last  = (setup_cnt == SW'(SETUP_CYC - 1));
  // Fires on the TIMEOUT-th wait cycle without a done pulse.
  assign wait_expire = (wait_cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = SETUP;
      SETUP:   if (setup_last) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (bus.spi_done || wait_expire) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      idx       <= '0;
      gnt_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      setup_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Requester inputs are captured here only; later changes are ignored.
          if (pick_valid) begin
            idx       <= pick_idx;
            gnt_q     <= pick_oh;
            cpol_q    <= bus.req_cpol[pick_idx];
            cpha_q    <= bus.req_cpha[pick_idx];
            tx_q      <= bus.req_tx[pick_idx*SPI_W +: SPI_W];
            err_q     <= 1'b0;
            setup_cnt <= '0;
          end
        end
        SETUP: setup_cnt <= setup_cnt + 1'b1;
        START: wait_cnt  <= '0;
        WAIT: begin
          // Done takes priority over a timeout expiring in the same cycle.
          if (bus.spi_done) begin
            rdata_q <= bus.spi_rx;
            err_q   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expire) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          gnt_q <= '0;
          ptr   <= IW'(wrap_inc(int'(idx), N_REQ));
        end
        default: ;
      endcase
    end
  end

  // Ack is gated by the grant register, so it can only reach the owner.
  assign bus.ack       = (state == RESP) ? gnt_q : '0;
  assign bus.gnt       = gnt_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.spi_start = (state == START);
  // Mode and TX registers are only reloaded at grant, so the engine sees a
  // stable clock level between transfers.
  assign bus.spi_cpol  = cpol_q;
  assign bus.spi_cpha  = cpha_q;
  assign bus.spi_tx    = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int N         = 4;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_arbiter_if #(.N_REQ(N)) bus ();

  spi_arbiter #(.N_REQ(N), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         idx;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] rdata;
    logic       err;
    int         waits;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  bit         eng_en  = 1'b1;
  int         eng_lat = 3;
  logic [7:0] eng_key = 8'hF0;
  int         eng_cnt = 0;

  // Latency L means done arrives in the L-th cycle after the start cycle.
  initial begin
    bus.spi_done = 1'b0;
    bus.spi_rx   = '0;
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (rst) eng_cnt = 0;
      else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.spi_done = 1'b1;
            bus.spi_rx   = bus.spi_tx ^ eng_key;
          end
        end
        if (bus.spi_start && eng_en) eng_cnt = eng_lat;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         rem[N];
  bit         in_setup, in_wait, mode_ok;
  int         setup_n, starts, waits;
  logic [N-1:0] prev_gnt;
  exp_t       mon_e;

  initial begin
    in_setup = 0; in_wait = 0; prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_setup = 0; in_wait = 0; prev_gnt = '0;
      end else begin
        if (bus.gnt != '0 && prev_gnt == '0) begin
          if (sb.size() == 0) check("unexpected_gnt", 32'(bus.gnt), 0);
          else begin
            check("gnt_owner", 32'(bus.gnt), 32'(1) << sb[0].idx);
            in_setup = 1;
          end
          in_wait = 0; setup_n = 0; starts = 0; waits = 0; mode_ok = 1;
        end
        if (bus.spi_start) begin
          starts++;
          if (in_setup) begin
            check("setup_cycles", setup_n, SETUP_CYC);
            check("setup_mode", 32'(mode_ok), 1);
            check("spi_tx", 32'(bus.spi_tx), 32'(sb[0].tx));
            in_setup = 0;
            in_wait  = 1;
          end
        end else if (in_setup && bus.gnt != '0) begin
          setup_n++;
          if ({bus.spi_cpol, bus.spi_cpha} !== {sb[0].cpol, sb[0].cpha}) mode_ok = 0;
        end else if (in_wait && bus.ack == '0) begin
          waits++;
        end
        if (bus.ack != '0) begin
          if (sb.size() == 0) check("unexpected_ack", 32'(bus.ack), 0);
          else begin
            mon_e = sb.pop_front();
            check("ack_onehot", 32'(bus.ack), 32'(1) << mon_e.idx);
            check("gnt_at_ack", 32'(bus.gnt), 32'(1) << mon_e.idx);
            check("rdata", 32'(bus.rdata), 32'(mon_e.rdata));
            check("err", 32'(bus.err), 32'(mon_e.err));
            check("start_count", starts, 1);
            check("wait_cycles", waits, mon_e.waits);
            rem[mon_e.idx]--;
            if (rem[mon_e.idx] <= 0) bus.req[mon_e.idx] = 1'b0;
          end
          in_wait = 0;
        end
        prev_gnt = bus.gnt;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int i, input logic cpol, input logic cpha, input logic [7:0] tx,
                      input logic [7:0] rd, input logic e, input int w);
    exp_t x;
    x.idx = i; x.cpol = cpol; x.cpha = cpha; x.tx = tx; x.rdata = rd; x.err = e; x.waits = w;
    sb.push_back(x);
  endtask

  task automatic set_req(input int i, input logic cpol, input logic cpha, input logic [7:0] tx,
                         input int n);
    bus.req_cpol[i]     = cpol;
    bus.req_cpha[i]     = cpha;
    bus.req_tx[i*8 +: 8] = tx;
    rem[i]              = n;
    bus.req[i]          = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'(sb.size()), bus.busy}, 0);
    sb.delete();
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.gnt, bus.ack, bus.rdata, bus.err, bus.busy,
            bus.spi_cpol, bus.spi_cpha, bus.spi_start, bus.spi_tx};
  endfunction

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    bus.req = '0; bus.req_cpol = '0; bus.req_cpha = '0; bus.req_tx = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, mode 0.
    eng_lat = 3;
    push(0, 1'b0, 1'b0, 8'h55, 8'hA5, 1'b0, 3);
    set_req(0, 1'b0, 1'b0, 8'h55, 1);
    wait_drain(100);

    // Mode 3 must persist on the engine pins after the transfer.
    eng_lat = 5;
    push(1, 1'b1, 1'b1, 8'h42, 8'h42 ^ 8'hF0, 1'b0, 5);
    set_req(1, 1'b1, 1'b1, 8'h42, 1);
    wait_drain(100);
    repeat (3) @(negedge clk);
    check("idle_mode_hold", 32'({bus.spi_cpol, bus.spi_cpha}), 32'b11);
    check("idle_busy", 32'(bus.busy), 0);

    // Round robin from ptr=0 with every requester holding req.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_clears_mode", 32'({bus.spi_cpol, bus.spi_cpha}), 0);
    eng_lat = 2;
    push(0, 1'b0, 1'b1, 8'h11, 8'h11 ^ 8'hF0, 1'b0, 2);
    push(1, 1'b1, 1'b0, 8'h22, 8'h22 ^ 8'hF0, 1'b0, 2);
    push(2, 1'b0, 1'b0, 8'h33, 8'h33 ^ 8'hF0, 1'b0, 2);
    push(3, 1'b1, 1'b1, 8'h44, 8'h44 ^ 8'hF0, 1'b0, 2);
    push(0, 1'b0, 1'b1, 8'h11, 8'h11 ^ 8'hF0, 1'b0, 2);
    set_req(0, 1'b0, 1'b1, 8'h11, 2);
    set_req(1, 1'b1, 1'b0, 8'h22, 1);
    set_req(2, 1'b0, 1'b0, 8'h33, 1);
    set_req(3, 1'b1, 1'b1, 8'h44, 1);
    wait_drain(300);

    // Engine silent: timeout, then normal service resumes.
    eng_en = 1'b0;
    push(2, 1'b0, 1'b0, 8'h77, 8'h00, 1'b1, TIMEOUT);
    set_req(2, 1'b0, 1'b0, 8'h77, 1);
    wait_drain(600);
    eng_en  = 1'b1;
    eng_lat = 2;
    push(3, 1'b1, 1'b0, 8'h99, 8'h99 ^ 8'hF0, 1'b0, 2);
    set_req(3, 1'b1, 1'b0, 8'h99, 1);
    wait_drain(100);

    // Done in the same cycle the timeout would expire.
    eng_lat = TIMEOUT;
    push(0, 1'b0, 1'b1, 8'hC3, 8'hC3 ^ 8'hF0, 1'b0, TIMEOUT);
    set_req(0, 1'b0, 1'b1, 8'hC3, 1);
    wait_drain(600);

    // Reset while waiting on the engine.
    eng_en = 1'b0;
    push(1, 1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 0);
    set_req(1, 1'b1, 1'b1, 8'h5A, 1);
    n = 0;
    while (!bus.spi_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(bus.spi_start), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_mid_outs", all_outs(), 0);
    sb.delete();
    bus.req = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    eng_en  = 1'b1;
    eng_lat = 2;
    @(negedge clk);

    // ptr back at 0: requester 1 beats 3, then 3 alone.
    push(1, 1'b0, 1'b0, 8'h10, 8'h10 ^ 8'hF0, 1'b0, 2);
    push(3, 1'b1, 1'b1, 8'h30, 8'h30 ^ 8'hF0, 1'b0, 2);
    set_req(1, 1'b0, 1'b0, 8'h10, 1);
    set_req(3, 1'b1, 1'b1, 8'h30, 1);
    wait_drain(200);
    push(3, 1'b0, 1'b1, 8'h3C, 8'h3C ^ 8'hF0, 1'b0, 2);
    set_req(3, 1'b0, 1'b1, 8'h3C, 1);
    wait_drain(100);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
